muldiv_hilo_ctrl: RTL

- Sequencer for the multi-cycle multiplier and divider plus owner of the architectural HI/LO registers.
- Sits beside the ALU in the execute stage.
  - Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO requests.
  - Launches the matching unit with a start/done handshake, commits results to HI/LO and generates the pipeline stall.
- The multiplier and divider stay external; this block holds their operands stable and captures their results.

---
 rtl/muldiv_pkg.sv | 34 +++
 rtl/muldiv_hilo_ctrl_hilo_regfile.sv | 52 +++++
 rtl/muldiv_hilo_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg
//   Shared types and constants for the HI/LO sequencer.
//   - muldiv_op_t : request opcode (OP_MULT .. OP_MFLO)
//   - state_t     : sequencer FSM state
//   - DATA_W/OP_W : datapath and opcode widths
//   - is_signed_op: true for the signed arithmetic ops (MULT, DIV)
package muldiv_pkg;

  localparam int DATA_W = 32;
  localparam int OP_W   = 3;

  typedef enum logic [OP_W-1:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_MFHI  = 3'd6,
    OP_MFLO  = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MUL_WAIT = 2'd1,
    ST_DIV_WAIT = 2'd2,
    ST_COMMIT   = 2'd3
  } state_t;

  function automatic logic is_signed_op(input muldiv_op_t op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_hilo_ctrl_hilo_regfile.sv
// hilo_regfile
//   The architectural HI and LO registers with independent write enables
//   and a read mux for MFHI/MFLO.
//   Ports:
//     clk, rst_n          clock, synchronous active-low reset (clears both)
//     hi_we, hi_wd        HI write enable / data
//     lo_we, lo_wd        LO write enable / data
//     rd_sel_hi           1 selects HI onto rd_data, 0 selects LO
//     hi, lo              current register contents
//     rd_data             combinational read port
module hilo_regfile
  import muldiv_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hi_we,
  input  logic [DATA_W-1:0] hi_wd,
  input  logic              lo_we,
  input  logic [DATA_W-1:0] lo_wd,
  input  logic              rd_sel_hi,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic [DATA_W-1:0] rd_data
);

  // Index 0 = LO, index 1 = HI.
  logic [DATA_W-1:0] we_data [2];
  logic [1:0]        we;
  logic [DATA_W-1:0] hilo_reg [2];

  assign we         = {hi_we, lo_we};
  assign we_data[0] = lo_wd;
  assign we_data[1] = hi_wd;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_reg
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          hilo_reg[gi] <= '0;
        end else if (we[gi]) begin
          hilo_reg[gi] <= we_data[gi];
        end
      end
    end
  endgenerate

  assign lo      = hilo_reg[0];
  assign hi      = hilo_reg[1];
  assign rd_data = rd_sel_hi ? hilo_reg[1] : hilo_reg[0];

endmodule

// File: rtl/muldiv_hilo_ctrl.sv
// muldiv_hilo_ctrl
//   Execute-stage sequencer for the external multiplier and divider, and
//   owner of the HI/LO registers. Launches a unit with a one-cycle start
//   pulse, holds its operands stable, waits for done, commits the result
//   to HI/LO and stalls the pipeline while the unit is busy.
//   Optional build macro: MULDIV_WATCHDOG_EN -- aborts a wait whose
//   busy_cycles count saturates and raises the sticky wd_err output.
//   Ports:
//     clk, rst_n                 clock, synchronous active-low reset
//     req_valid, req_op          HI/LO-class request and its opcode
//     src_a, src_b               rs / rt operands
//     unit_a, unit_b, unit_sign  registered operands/signedness to units
//     mul_start, mul_done        multiplier handshake
//     mul_hi, mul_lo             multiplier result
//     div_start, div_done        divider handshake
//     div_hi, div_lo             divider remainder / quotient
//     stall                      pipeline freeze upstream of execute
//     rd_data                    MFHI/MFLO read data
//     wd_err                     (watchdog builds only) sticky timeout flag
//     busy_cycles                saturating cycle count of current wait
module muldiv_hilo_ctrl
  import muldiv_pkg::*;
#(
  parameter int TIMEOUT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  input  logic [OP_W-1:0]      req_op,
  input  logic [DATA_W-1:0]    src_a,
  input  logic [DATA_W-1:0]    src_b,
  output logic [DATA_W-1:0]    unit_a,
  output logic [DATA_W-1:0]    unit_b,
  output logic                 unit_sign,
  output logic                 mul_start,
  input  logic                 mul_done,
  input  logic [DATA_W-1:0]    mul_hi,
  input  logic [DATA_W-1:0]    mul_lo,
  output logic                 div_start,
  input  logic                 div_done,
  input  logic [DATA_W-1:0]    div_hi,
  input  logic [DATA_W-1:0]    div_lo,
  output logic                 stall,
  output logic [DATA_W-1:0]    rd_data,
`ifdef MULDIV_WATCHDOG_EN
  output logic                 wd_err,
`endif
  output logic [TIMEOUT_W-1:0] busy_cycles
);

  muldiv_op_t op;
  assign op = muldiv_op_t'(req_op);

  state_t               state_reg;
  logic [DATA_W-1:0]    unit_a_reg;
  logic [DATA_W-1:0]    unit_b_reg;
  logic                 unit_sign_reg;
  logic                 mul_start_reg;
  logic                 div_start_reg;
  logic [TIMEOUT_W-1:0] busy_reg;
  logic [TIMEOUT_W-1:0] busy_next;

  logic                 launch_mul;
  logic                 launch_div;
  logic                 waiting;
  logic                 unit_done;
  logic                 hi_we;
  logic                 lo_we;
  logic [DATA_W-1:0]    hi_wd;
  logic [DATA_W-1:0]    lo_wd;
  logic                 wd_hit;

  assign waiting   = (state_reg == ST_MUL_WAIT) || (state_reg == ST_DIV_WAIT);
  // Only the unit actually launched may end the wait; the other unit's
  // done pulse is noise.
  assign unit_done = ((state_reg == ST_MUL_WAIT) && mul_done) ||
                     ((state_reg == ST_DIV_WAIT) && div_done);
  assign busy_next = (busy_reg == {TIMEOUT_W{1'b1}}) ? busy_reg : busy_reg + 1'b1;

`ifdef MULDIV_WATCHDOG_EN
  logic wd_err_reg;
  assign wd_hit = waiting && !unit_done && (busy_reg == {TIMEOUT_W{1'b1}});
  assign wd_err = wd_err_reg;
`else
  assign wd_hit = 1'b0;
`endif

  // Request decode and HI/LO write steering.
  always_comb begin
    launch_mul = 1'b0;
    launch_div = 1'b0;
    hi_we      = 1'b0;
    lo_we      = 1'b0;
    hi_wd      = '0;
    lo_wd      = '0;
    if (state_reg == ST_IDLE && req_valid) begin
      case (op)
        OP_MULT, OP_MULTU: launch_mul = 1'b1;
        // Divide by zero is architecturally undefined: treat as a no-op.
        OP_DIV, OP_DIVU:   launch_div = (src_b != '0);
        OP_MTHI: begin
          hi_we = 1'b1;
          hi_wd = src_a;
        end
        OP_MTLO: begin
          lo_we = 1'b1;
          lo_wd = src_a;
        end
        default: ;
      endcase
    end
    if (unit_done) begin
      hi_we = 1'b1;
      lo_we = 1'b1;
      if (state_reg == ST_MUL_WAIT) begin
        hi_wd = mul_hi;
        lo_wd = mul_lo;
      end else begin
        hi_wd = div_hi;
        lo_wd = div_lo;
      end
    end
  end

  // Stall covers the launching request cycle plus the whole wait; the
  // COMMIT cycle is stall-free so the held instruction can retire.
  assign stall = launch_mul || launch_div || waiting;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      unit_a_reg    <= '0;
      unit_b_reg    <= '0;
      unit_sign_reg <= 1'b0;
      mul_start_reg <= 1'b0;
      div_start_reg <= 1'b0;
      busy_reg      <= '0;
`ifdef MULDIV_WATCHDOG_EN
      wd_err_reg    <= 1'b0;
`endif
    end else begin
      mul_start_reg <= 1'b0;
      div_start_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          busy_reg <= '0;
          if (launch_mul || launch_div) begin
            unit_a_reg    <= src_a;
            unit_b_reg    <= src_b;
            unit_sign_reg <= is_signed_op(op);
            mul_start_reg <= launch_mul;
            div_start_reg <= launch_div;
            state_reg     <= launch_mul ? ST_MUL_WAIT : ST_DIV_WAIT;
          end
        end
        ST_MUL_WAIT, ST_DIV_WAIT: begin
          busy_reg <= busy_next;
          if (unit_done) begin
            state_reg <= ST_COMMIT;
          end else if (wd_hit) begin
            state_reg  <= ST_COMMIT;
`ifdef MULDIV_WATCHDOG_EN
            wd_err_reg <= 1'b1;
`endif
          end
        end
        ST_COMMIT: begin
          // req_valid here is the retiring instruction itself; ignore it.
          busy_reg  <= '0;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign unit_a      = unit_a_reg;
  assign unit_b      = unit_b_reg;
  assign unit_sign   = unit_sign_reg;
  assign mul_start   = mul_start_reg;
  assign div_start   = div_start_reg;
  assign busy_cycles = busy_reg;

  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;

  hilo_regfile u_hilo (
    .clk       (clk),
    .rst_n     (rst_n),
    .hi_we     (hi_we),
    .hi_wd     (hi_wd),
    .lo_we     (lo_we),
    .lo_wd     (lo_wd),
    .rd_sel_hi (op == OP_MFHI),
    .hi        (hi_q),
    .lo        (lo_q),
    .rd_data   (rd_data)
  );

endmodule
